// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition check and gated E->M enable pipeline register
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagWE,
    input  logic             PCSE,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             NoWriteE,
    output logic             CondExE,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             ValidM,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCnt
);
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_pass;
    logic             commit;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags_q;
    assign commit       = ValidE & ~StallE & ~FlushE;
    assign CondExE      = cond_pass & ValidE & ~FlushE;

    // Decode the condition field against the registered flags only
    always_comb begin
        cond_pass = 1'b0;
        case (CondE)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = n == v;
            4'b1011: cond_pass = n != v;
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Next state: flag update, M-stage enables {PCSrc, RegWrite, MemWrite, Valid}, squash counter
    always_comb begin
        flags_d = flags_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        if (commit) begin
            if (CondExE && FlagWE[1]) flags_d[3:2] = ALUFlags[3:2];
            if (CondExE && FlagWE[0]) flags_d[1:0] = ALUFlags[1:0];
            m_d = {PCSE & CondExE, RegWE & ~NoWriteE & CondExE, MemWE & CondExE, 1'b1};
            if (!CondExE && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (!StallE || FlushE) begin
            m_d = '0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Flags     = flags_q;
    assign {PCSrcM, RegWriteM, MemWriteM, ValidM} = m_q;
    assign SquashCnt = cnt_q;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed vector table plus stall/flush, saturation and async reset sequences
module tb_cond_unit;
    logic clk = 1'b0;
    logic reset;
    logic ValidE, StallE, FlushE, PCSE, RegWE, MemWE, NoWriteE;
    logic [3:0] CondE, ALUFlags;
    logic [1:0] FlagWE;
    logic CondExE, PCSrcM, RegWriteM, MemWriteM, ValidM;
    logic [3:0] Flags;
    logic [15:0] SquashCnt;
    logic CondExE2, PCSrcM2, RegWriteM2, MemWriteM2, ValidM2;
    logic [3:0] Flags2;
    logic [1:0] SquashCnt2;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .ALUFlags(ALUFlags), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE),
        .MemWE(MemWE), .NoWriteE(NoWriteE), .CondExE(CondExE), .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ValidM(ValidM), .Flags(Flags),
        .SquashCnt(SquashCnt)
    );

    cond_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .ALUFlags(ALUFlags), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE),
        .MemWE(MemWE), .NoWriteE(NoWriteE), .CondExE(CondExE2), .PCSrcM(PCSrcM2),
        .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2), .ValidM(ValidM2), .Flags(Flags2),
        .SquashCnt(SquashCnt2)
    );

    typedef struct {
        logic       v, s, f;
        logic [3:0] cond, alu;
        logic [1:0] fwe;
        logic       pcs, rwe, mwe, nw;
        logic       e_cx;
        logic [3:0] e_flags;
        logic       e_pc, e_rw, e_mw, e_vm;
        int         e_cnt;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, s, f, input logic [3:0] cond, alu, input logic [1:0] fwe,
                         input logic pcs, rwe, mwe, nw);
        ValidE = v; StallE = s; FlushE = f; CondE = cond; ALUFlags = alu; FlagWE = fwe;
        PCSE = pcs; RegWE = rwe; MemWE = mwe; NoWriteE = nw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m(input string name, input logic [3:0] exp);
        chk(name, {PCSrcM, RegWriteM, MemWriteM, ValidM}, exp);
    endtask

    initial begin
        // v s f cond alu fwe pcs rwe mwe nw | cx flags pc rw mw vm cnt
        tbl[0]  = '{0,0,0,4'b0000,4'b0000,2'b00,0,0,0,0, 0,4'b0000,0,0,0,0,0};
        tbl[1]  = '{1,0,0,4'b1110,4'b0100,2'b11,0,0,0,0, 1,4'b0100,0,0,0,1,0};
        tbl[2]  = '{1,0,0,4'b0000,4'b0000,2'b00,0,1,0,0, 1,4'b0100,0,1,0,1,0};
        tbl[3]  = '{1,0,0,4'b0001,4'b1000,2'b11,0,0,1,0, 0,4'b0100,0,0,0,1,1};
        tbl[4]  = '{1,0,0,4'b1110,4'b1111,2'b11,1,0,0,0, 1,4'b1111,1,0,0,1,1};
        tbl[5]  = '{1,0,0,4'b1110,4'b0000,2'b01,0,0,0,0, 1,4'b1100,0,0,0,1,1};
        tbl[6]  = '{1,0,0,4'b1011,4'b0000,2'b00,0,1,0,1, 1,4'b1100,0,0,0,1,1};
        tbl[7]  = '{1,0,1,4'b1011,4'b1111,2'b11,1,1,1,0, 0,4'b1100,0,0,0,0,1};
        tbl[8]  = '{1,0,0,4'b1010,4'b0000,2'b00,0,1,0,0, 0,4'b1100,0,0,0,1,2};
        tbl[9]  = '{1,0,0,4'b1001,4'b0000,2'b00,0,0,1,0, 1,4'b1100,0,0,1,1,2};
        tbl[10] = '{1,0,0,4'b1000,4'b0000,2'b00,0,0,0,0, 0,4'b1100,0,0,0,1,3};
        tbl[11] = '{1,0,0,4'b1100,4'b0000,2'b00,0,0,0,0, 0,4'b1100,0,0,0,1,4};
        tbl[12] = '{1,0,0,4'b1101,4'b0000,2'b00,1,0,0,0, 1,4'b1100,1,0,0,1,4};
        tbl[13] = '{1,0,0,4'b0100,4'b0010,2'b10,0,1,0,0, 1,4'b0000,0,1,0,1,4};
        tbl[14] = '{1,0,0,4'b0101,4'b0011,2'b01,0,0,0,0, 1,4'b0011,0,0,0,1,4};
        tbl[15] = '{1,0,0,4'b0010,4'b0000,2'b00,0,1,0,0, 1,4'b0011,0,1,0,1,4};
        tbl[16] = '{1,0,0,4'b0011,4'b0000,2'b00,0,0,0,0, 0,4'b0011,0,0,0,1,5};
        tbl[17] = '{1,0,0,4'b0110,4'b0000,2'b00,0,0,1,0, 1,4'b0011,0,0,1,1,5};
        tbl[18] = '{1,0,0,4'b0111,4'b0000,2'b00,0,0,0,0, 0,4'b0011,0,0,0,1,6};
        tbl[19] = '{0,0,0,4'b1110,4'b1111,2'b11,1,1,1,0, 0,4'b0011,0,0,0,0,6};

        // Reset and idle
        drive(0,0,0,4'b0000,4'b0000,2'b00,0,0,0,0);
        reset = 1'b0;
        tick();
        tick();
        chk("reset_flags", Flags, 4'b0000);
        chk_m("reset_m", 4'b0000);
        chk("reset_cnt", SquashCnt, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_flags", Flags, 4'b0000);
            chk("idle_valid", ValidM, 1'b0);
            chk("idle_cnt", SquashCnt, 0);
        end

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].cond, tbl[i].alu, tbl[i].fwe,
                  tbl[i].pcs, tbl[i].rwe, tbl[i].mwe, tbl[i].nw);
            #1;
            chk($sformatf("vec%0d_condex", i), CondExE, tbl[i].e_cx);
            tick();
            chk($sformatf("vec%0d_flags", i), Flags, tbl[i].e_flags);
            chk_m($sformatf("vec%0d_m", i), {tbl[i].e_pc, tbl[i].e_rw, tbl[i].e_mw, tbl[i].e_vm});
            chk($sformatf("vec%0d_cnt", i), SquashCnt, tbl[i].e_cnt);
        end

        // Load M stage, then stall three cycles, then stall+flush
        drive(1,0,0,4'b1110,4'b0000,2'b00,1,1,0,0);
        tick();
        chk_m("pre_stall_m", 4'b1101);
        drive(1,1,0,4'b1110,4'b1100,2'b11,0,0,1,0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_condex", CondExE, 1'b1);
            tick();
            chk("stall_flags", Flags, 4'b0011);
            chk_m("stall_m", 4'b1101);
            chk("stall_cnt", SquashCnt, 6);
        end
        FlushE = 1'b1;
        #1;
        chk("stflush_condex", CondExE, 1'b0);
        tick();
        chk("stflush_flags", Flags, 4'b0011);
        chk_m("stflush_m", 4'b0000);
        chk("stflush_cnt", SquashCnt, 6);

        // Asynchronous reset between edges
        drive(0,0,0,4'b0000,4'b0000,2'b00,0,0,0,0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_flags", Flags, 4'b0000);
        chk("async_rst_cnt", SquashCnt, 0);
        tick();
        reset = 1'b1;

        // Saturation on the 2-bit counter
        drive(1,0,0,4'b1111,4'b1111,2'b11,1,1,1,0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("nv_condex", CondExE, 1'b0);
            tick();
            chk("sat_cnt2", SquashCnt2, (i < 3) ? i + 1 : 3);
            chk("sat_cnt16", SquashCnt, i + 1);
            chk("sat_flags", Flags2, 4'b0000);
            chk("sat_valid", ValidM2, 1'b1);
        end
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_cnt2", SquashCnt2, 0);
        chk("midrst_cnt16", SquashCnt, 0);
        chk("midrst_valid", ValidM, 1'b0);
        drive(0,0,0,4'b0000,4'b0000,2'b00,0,0,0,0);
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
